// File: rtl/btb_update_unit.sv
// BTB update unit: classifies resolved branches against the fetch-time BTB
// prediction, issues a registered fetch redirect on mispredict, and queues
// BTB write/invalidate requests in a small coalescing FIFO that drains over
// a valid/ready handshake. Saturating mispredict and drop counters.
module btb_update_unit #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_hit,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [ADDR_WIDTH-1:0] upd_pc,
  output logic [ADDR_WIDTH-1:0] upd_target,
  output logic                  upd_inval,
  output logic                  fifo_full,
  output logic [CNT_WIDTH-1:0]  mispredict_count,
  output logic [7:0]            drop_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    CORRECT,
    MISS_TAKEN,
    WRONG_TGT,
    FALSE_HIT
  } br_class_e;

  br_class_e             cls;
  logic                  mispredict;
  logic                  new_inval;
  logic [ADDR_WIDTH-1:0] new_target;
  logic [ADDR_WIDTH-1:0] redir_pc;

  logic [ADDR_WIDTH-1:0] pc_q    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_q   [FIFO_DEPTH];
  logic                  inval_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [OCC_W-1:0]      count_q, count_d;

  logic                  redirect_valid_q;
  logic [ADDR_WIDTH-1:0] redirect_pc_q;
  logic [CNT_WIDTH-1:0]  mis_cnt_q;
  logic [7:0]            drop_cnt_q;

  logic                  deq;
  logic                  hit_any;
  logic [PTR_W-1:0]      hit_idx;
  logic [PTR_W-1:0]      off;
  logic                  do_coal, do_app, do_drop;

  // Classify the resolved branch against the fetch-time prediction.
  always_comb begin
    cls = CORRECT;
    if (ex_valid) begin
      if (ex_taken && !ex_pred_hit)                        cls = MISS_TAKEN;
      else if (ex_taken && ex_pred_target != ex_target)    cls = WRONG_TGT;
      else if (!ex_taken && ex_pred_hit)                   cls = FALSE_HIT;
    end
  end

  assign mispredict = (cls != CORRECT);
  assign new_inval  = (cls == FALSE_HIT);
  assign new_target = new_inval ? '0 : ex_target;
  assign redir_pc   = new_inval ? (ex_pc + ADDR_WIDTH'(4)) : ex_target;

  assign deq = (count_q != '0) && upd_ready;

  // Search occupied slots for a matching PC; the head is excluded while it
  // is leaving this cycle so the update is appended behind it instead.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    off     = '0;
    for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
      off = PTR_W'(j) - head_q;
      if (({1'b0, off} < count_q) && !(deq && PTR_W'(j) == head_q) &&
          pc_q[j] == ex_pc) begin
        hit_any = 1'b1;
        hit_idx = PTR_W'(j);
      end
    end
  end

  assign do_coal = mispredict && hit_any;
  assign do_app  = mispredict && !hit_any &&
                   ((count_q < OCC_W'(FIFO_DEPTH)) || deq);
  assign do_drop = mispredict && !hit_any && !do_app;

  assign count_d = count_q + OCC_W'(do_app) - OCC_W'(deq);

  // Queue pointers, occupancy, redirect and performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mis_cnt_q        <= '0;
      drop_cnt_q       <= '0;
    end else begin
      head_q           <= head_q + PTR_W'(deq);
      tail_q           <= tail_q + PTR_W'(do_app);
      count_q          <= count_d;
      redirect_valid_q <= mispredict;
      if (mispredict) redirect_pc_q <= redir_pc;
      if (mispredict && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 1'b1;
      if (do_drop && drop_cnt_q != '1)   drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  // Entry storage: coalesce in place or append at the tail.
  always_ff @(posedge clk) begin
    if (do_coal) begin
      tgt_q[hit_idx]   <= new_target;
      inval_q[hit_idx] <= new_inval;
    end else if (do_app) begin
      pc_q[tail_q]    <= ex_pc;
      tgt_q[tail_q]   <= new_target;
      inval_q[tail_q] <= new_inval;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign upd_valid        = (count_q != '0);
  assign fifo_full        = (count_q == OCC_W'(FIFO_DEPTH));
  assign upd_pc           = pc_q[head_q];
  assign upd_target       = tgt_q[head_q];
  assign upd_inval        = inval_q[head_q];
  assign mispredict_count = mis_cnt_q;
  assign drop_count       = drop_cnt_q;

endmodule

// File: tb/tb_btb_update_unit.sv
// Testbench for btb_update_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_btb_update_unit;

  localparam int unsigned AW    = 26;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic [AW-1:0] ex_pc;
  logic          ex_taken;
  logic [AW-1:0] ex_target;
  logic          ex_pred_hit;
  logic [AW-1:0] ex_pred_target;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          upd_valid;
  logic          upd_ready;
  logic [AW-1:0] upd_pc;
  logic [AW-1:0] upd_target;
  logic          upd_inval;
  logic          fifo_full;
  logic [15:0]   mispredict_count;
  logic [7:0]    drop_count;

  btb_update_unit #(
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_taken        (ex_taken),
    .ex_target       (ex_target),
    .ex_pred_hit     (ex_pred_hit),
    .ex_pred_target  (ex_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .upd_inval       (upd_inval),
    .fifo_full       (fifo_full),
    .mispredict_count(mispredict_count),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    logic          inval;
  } ent_t;

  ent_t          mq[$];
  int            m_mis;
  int            m_drop;
  logic          m_rv;
  logic [AW-1:0] m_rpc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    if (m_rv) check("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
    check("upd_valid", 32'(upd_valid), 32'(mq.size() != 0));
    check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    if (mq.size() != 0) begin
      check("upd_pc",     32'(upd_pc),     32'(mq[0].pc));
      check("upd_target", 32'(upd_target), 32'(mq[0].tgt));
      check("upd_inval",  32'(upd_inval),  32'(mq[0].inval));
    end
    check("mispredict_count", 32'(mispredict_count), 32'(m_mis));
    check("drop_count",       32'(drop_count),       32'(m_drop));
  endtask

  // Drive one cycle of stimulus, advance the model, clock, then compare.
  task automatic step(input logic v, input logic [AW-1:0] pc, input logic tk,
                      input logic [AW-1:0] tgt, input logic hit,
                      input logic [AW-1:0] ptgt, input logic rdy);
    bit            deq, mis, inv, app;
    logic [AW-1:0] wt;
    int            idx;
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_hit = hit; ex_pred_target = ptgt; upd_ready = rdy;
    deq = (mq.size() > 0) && rdy;
    mis = 0; inv = 0; wt = tgt; app = 0;
    if (v) begin
      if (tk && (!hit || ptgt != tgt)) mis = 1;
      else if (!tk && hit) begin mis = 1; inv = 1; wt = '0; end
    end
    m_rv = mis;
    idx = -1;
    if (mis) begin
      m_rpc = inv ? pc + AW'(4) : tgt;
      if (m_mis < 65535) m_mis++;
      for (int i = (deq ? 1 : 0); i < mq.size(); i++)
        if (mq[i].pc == pc) idx = i;
      if (idx >= 0) begin
        mq[idx].tgt = wt;
        mq[idx].inval = inv;
      end else if (mq.size() < DEPTH || deq) begin
        app = 1;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    if (deq) void'(mq.pop_front());
    if (app) mq.push_back('{pc: pc, tgt: wt, inval: inv});
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    m_mis = 0; m_drop = 0; m_rv = 1'b0; m_rpc = '0;
    check_outputs();
    check("reset_redirect_pc", 32'(redirect_pc), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  initial begin
    logic [AW-1:0] rpc, rtgt, rptgt;
    logic          rv, rtk, rhit, rrdy;
    rst_n = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_hit = 1'b0; ex_pred_target = '0; upd_ready = 1'b0;
    m_mis = 0; m_drop = 0; m_rv = 1'b0; m_rpc = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Taken miss, then drain.
    step(1'b1, 26'h100, 1'b1, 26'h200, 1'b0, '0, 1'b0);
    check("tp1_redirect_pc", 32'(redirect_pc), 32'h200);
    check("tp1_upd_pc", 32'(upd_pc), 32'h100);
    idle(1'b1);

    // False hits, including PC+4 wrap.
    step(1'b1, 26'h300, 1'b0, '0, 1'b1, 26'h500, 1'b1);
    check("tp2_redirect_pc", 32'(redirect_pc), 32'h304);
    step(1'b1, 26'h3FFFFFC, 1'b0, '0, 1'b1, 26'h500, 1'b1);
    check("tp2_wrap_pc", 32'(redirect_pc), 32'h0);
    idle(1'b1); idle(1'b1);

    // Coalescing of the same PC while stalled.
    step(1'b1, 26'h40, 1'b1, 26'h80, 1'b0, '0, 1'b0);
    step(1'b1, 26'h40, 1'b1, 26'hC0, 1'b0, '0, 1'b0);
    check("tp3_target", 32'(upd_target), 32'hC0);
    idle(1'b1); idle(1'b1);

    // Fill, overflow drop, then drain in order.
    for (int i = 0; i < 5; i++)
      step(1'b1, AW'(26'h1000 + 16 * i), 1'b1, AW'(26'h2000 + 16 * i), 1'b0, '0, 1'b0);
    check("tp4_drop", 32'(drop_count), 32'h1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Full with simultaneous dequeue and new entry; then a correct prediction.
    for (int i = 0; i < 4; i++)
      step(1'b1, AW'(26'h4000 + 16 * i), 1'b1, AW'(26'h5000), 1'b0, '0, 1'b0);
    step(1'b1, 26'h6000, 1'b1, 26'h7000, 1'b0, '0, 1'b1);
    check("tp5_full", 32'(fifo_full), 32'h1);
    step(1'b1, 26'h8000, 1'b1, 26'h9000, 1'b1, 26'h9000, 1'b0);
    // Head-leaving match falls through to append behind it.
    step(1'b1, 26'h4010, 1'b1, 26'h1234, 1'b0, '0, 1'b1);
    // Drop counter saturation.
    for (int i = 0; i < 260; i++)
      step(1'b1, AW'(26'h10000 + 4 * i), 1'b1, AW'(26'h20000), 1'b0, '0, 1'b0);
    check("drop_sat", 32'(drop_count), 32'hFF);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Reset mid-operation with entries queued and a mispredict in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, AW'(26'hA000 + 16 * i), 1'b1, AW'(26'hB000), 1'b0, '0, 1'b0);
    ex_valid = 1'b1; ex_pc = 26'hC000; ex_taken = 1'b1; ex_pred_hit = 1'b0;
    do_reset();

    // Randomized traffic over a small PC pool to exercise coalescing.
    for (int n = 0; n < 3000; n++) begin
      rv    = ($urandom_range(0, 9) < 8);
      rpc   = ($urandom_range(0, 15) == 0) ? AW'(26'h3FFFFFC)
                                           : AW'(26'h1000 + 4 * $urandom_range(0, 7));
      rtk   = 1'($urandom_range(0, 1));
      rtgt  = AW'({$urandom_range(0, 3), 2'b00});
      rhit  = 1'($urandom_range(0, 1));
      rptgt = ($urandom_range(0, 1) == 1) ? rtgt : AW'({$urandom_range(0, 3), 2'b00});
      rrdy  = ($urandom_range(0, 9) < 4);
      step(rv, rpc, rtk, rtgt, rhit, rptgt, rrdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
